alu_arb_ctrl: RTL and testbench
===============================

ALU_ARB_CTRL -- requirements
Module: alu_arb_ctrl

Interface
REQ-001 SHALL have parameter NUM_REQ, 4, number of requesters (2..8).
REQ-002 SHALL have parameter DATA_W, 8, operand/result width.
REQ-003 SHALL have parameter OP_W, 3, operator width.
REQ-004 SHALL have parameter ALU_LAT, 1, ALU cycles from data_in strobe to valid result (>=1).
REQ-005 SHALL have ports: clock  in  1  sole clock, all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 req_valid  in  NUM_REQ  per-requester operation request.
REQ-008 req_ready  out  NUM_REQ  per-requester accept (one-hot or zero).
REQ-009 req_a, req_b  in  NUM_REQ*DATA_W  packed operands, requester i at slice i.
REQ-010 req_op  in  NUM_REQ*OP_W  packed operator codes.
REQ-011 alu_input_a, alu_input_b  out  DATA_W  ALU operands.
REQ-012 alu_operator  out  OP_W  ALU operator.
REQ-013 alu_data_in  out  1  ALU operand-valid strobe.
REQ-014 alu_result  in  DATA_W  ALU result.
REQ-015 rsp_valid  out  1, rsp_ready  in  1  response handshake.
REQ-016 rsp_id  out  $clog2(NUM_REQ)  granted requester index; rsp_result  out  DATA_W.
REQ-017 busy  out  1  high whenever state != IDLE.

Function
REQ-018 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE; one operation in flight, no overlap.
REQ-019 IDLE: if any req_valid, arbiter grant g selected combinationally; req_ready[g]=1 same cycle; transfer when req_valid[g]&req_ready[g]; operands/op/id latched; next ISSUE.
REQ-020 IDLE with no req_valid: stay, req_ready=0.
REQ-021 ISSUE: alu_data_in=1 for exactly one cycle; latch-load wait counter with ALU_LAT-1; next WAIT.
REQ-022 WAIT: lasts exactly ALU_LAT cycles; on last cycle alu_result captured into rsp_result; next RESP.
REQ-023 Latency: accept in cycle T -> alu_data_in in T+1 -> rsp_valid first high in T+2+ALU_LAT.
REQ-024 RESP: rsp_valid=1, rsp_id/rsp_result stable until rsp_valid&rsp_ready; then IDLE same edge.
REQ-025 rsp_ready low SHALL stall indefinitely; req_ready stays 0 during ISSUE/WAIT/RESP.
REQ-026 alu_input_a/b/operator SHALL hold latched values in ISSUE/WAIT/RESP; drive zero in IDLE.
REQ-027 Default arbitration round-robin: search starts at pointer p; on response handshake p <= (g+1) mod NUM_REQ.
REQ-028 req_valid dropping before grant: no effect, no record kept.
REQ-029 Peak throughput: one operation per 3+ALU_LAT cycles with rsp_ready held high.

Reset
REQ-030 reset SHALL force state IDLE, p=0, counter=0, all outputs 0 (req_ready, alu_*, rsp_*, busy).
REQ-031 reset mid-operation SHALL discard the in-flight operation with no response.
REQ-032 req_valid during reset SHALL be ignored; first grant possible the cycle after reset deasserts.

Configuration
REQ-033 Macro ALU_ARB_FIXED_PRIO_EN defined: fixed priority, lowest asserted index wins, pointer logic removed.
REQ-034 Macro undefined: round-robin per REQ-027.

Structure
REQ-035 Package alu_arb_pkg SHALL hold state enum (IDLE, ISSUE, WAIT, RESP) and default parameter constants.
REQ-036 Arbitration SHALL be sub-module alu_rr_arbiter (req vector, pointer in; one-hot grant, index out).

Verification (stub ALU: alu_result = a+b registered ALU_LAT cycles after alu_data_in; ALU_LAT=1)
REQ-037 req0 a=8'h12 b=8'h34 op=0 at T, rsp_ready=1 -> req_ready[0] at T, alu_data_in at T+1, rsp_valid T+3, rsp_id=0, rsp_result=8'h46.
REQ-038 req_valid=4'b1111 held, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0; with FIXED_PRIO_EN -> 0,0,0,0.
REQ-039 rsp_ready=0 for 10 cycles in RESP -> rsp_valid, rsp_result constant, busy=1, req_ready=0 throughout.
REQ-040 reset pulsed in WAIT -> no rsp_valid, outputs 0 next cycle, next grant is req0 (p=0).
REQ-041 req2 a=8'hFF b=8'h01 -> rsp_result=8'h00 (wrap, no carry), rsp_id=2.
REQ-042 req1 valid one cycle while busy, then dropped -> never granted, never responded.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared state encoding and default parameters for the ALU arbiter controller
package alu_arb_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_OP_W    = 3;
  localparam int DEF_ALU_LAT = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/alu_rr_arbiter.sv
// rtl/alu_rr_arbiter.sv - rotating-start arbiter: first asserted request at or after ptr wins
module alu_rr_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = $clog2(DEF_NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic found;
  int   idx;

  // Walk the requesters starting at ptr, wrapping once; the first hit is granted.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/alu_arb_ctrl.sv
// rtl/alu_arb_ctrl.sv - arbitrates requesters onto one shared ALU, one operation in flight (ALU_ARB_FIXED_PRIO_EN selects fixed priority)
module alu_arb_ctrl
  import alu_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int OP_W    = DEF_OP_W,
  parameter int ALU_LAT = DEF_ALU_LAT,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ*OP_W-1:0]   req_op,
  output logic [DATA_W-1:0]         alu_input_a,
  output logic [DATA_W-1:0]         alu_input_b,
  output logic [OP_W-1:0]           alu_operator,
  output logic                      alu_data_in,
  input  logic [DATA_W-1:0]         alu_result,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [IDX_W-1:0]          rsp_id,
  output logic [DATA_W-1:0]         rsp_result,
  output logic                      busy
);

  localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  state_t              state;
  state_t              state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    ptr;
  logic [NUM_REQ-1:0]  grant;
  logic [IDX_W-1:0]    grant_idx;
  logic [DATA_W-1:0]   lat_a;
  logic [DATA_W-1:0]   lat_b;
  logic [OP_W-1:0]     lat_op;
  logic [IDX_W-1:0]    lat_id;
  logic [DATA_W-1:0]   res_q;
  logic                accept;
  logic                rsp_fire;

  alu_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // A grant is only a transfer while idle and out of reset; the arbiter only grants valid requesters.
  assign accept   = (state == IDLE) && !reset && (|grant);
  assign rsp_fire = (state == RESP) && rsp_ready;

`ifdef ALU_ARB_FIXED_PRIO_EN
  // Search always starts at requester 0, so the lowest asserted index wins.
  assign ptr = '0;
`else
  // Rotate the search start to just past the requester whose response completed.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr <= '0;
    end else if (rsp_fire) begin
      ptr <= (lat_id == IDX_W'(NUM_REQ - 1)) ? '0 : lat_id + 1'b1;
    end
  end
`endif

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: strictly sequential, no overlap between operations.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (cnt == '0) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture at accept, wait countdown, and result capture on the last wait cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt    <= '0;
      lat_a  <= '0;
      lat_b  <= '0;
      lat_op <= '0;
      lat_id <= '0;
      res_q  <= '0;
    end else begin
      if (accept) begin
        lat_a  <= req_a[grant_idx*DATA_W +: DATA_W];
        lat_b  <= req_b[grant_idx*DATA_W +: DATA_W];
        lat_op <= req_op[grant_idx*OP_W +: OP_W];
        lat_id <= grant_idx;
      end
      if (state == ISSUE) begin
        cnt <= CNT_W'(ALU_LAT - 1);
      end else if (state == WAIT) begin
        if (cnt == '0) begin
          res_q <= alu_result;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

  // Outputs: ALU operands only leave the block while an operation owns the ALU.
  always_comb begin
    req_ready    = '0;
    alu_input_a  = '0;
    alu_input_b  = '0;
    alu_operator = '0;
    alu_data_in  = 1'b0;
    rsp_valid    = 1'b0;
    busy         = 1'b0;
    if (state == IDLE) begin
      if (!reset) req_ready = grant;
    end else begin
      alu_input_a  = lat_a;
      alu_input_b  = lat_b;
      alu_operator = lat_op;
      busy         = 1'b1;
    end
    alu_data_in = (state == ISSUE);
    rsp_valid   = (state == RESP);
  end

  assign rsp_id     = lat_id;
  assign rsp_result = res_q;

endmodule

// File: tb/tb_alu_arb_ctrl.sv
// tb/tb_alu_arb_ctrl.sv - directed self-checking bench for alu_arb_ctrl with a registered adder ALU stub
module tb_alu_arb_ctrl;

  logic        clock;
  logic        reset;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [11:0] req_op;
  logic [7:0]  alu_input_a;
  logic [7:0]  alu_input_b;
  logic [2:0]  alu_operator;
  logic        alu_data_in;
  logic [7:0]  alu_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_result;
  logic        busy;

  int checks;
  int failures;
  int exp_ids [5];
  logic [3:0] onehot;

  alu_arb_ctrl #(
    .NUM_REQ (4),
    .DATA_W  (8),
    .OP_W    (3),
    .ALU_LAT (1)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_op       (req_op),
    .alu_input_a  (alu_input_a),
    .alu_input_b  (alu_input_b),
    .alu_operator (alu_operator),
    .alu_data_in  (alu_data_in),
    .alu_result   (alu_result),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_result   (rsp_result),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  always_ff @(posedge clock) begin
    if (reset) begin
      alu_result <= '0;
    end else if (alu_data_in) begin
      alu_result <= alu_input_a + alu_input_b;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    req_a[i*8 +: 8]  = a;
    req_b[i*8 +: 8]  = b;
    req_op[i*3 +: 3] = op;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_ids   = '{0, 0, 0, 0, 0};
`else
    exp_ids   = '{0, 1, 2, 3, 0};
`endif
    clock     = 1'b0;
    reset     = 1'b1;
    req_valid = 4'b1111;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 1'b1;

    tick;
    tick;
    chk("reset_req_ready", 32'(req_ready), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset_alu_data_in", 32'(alu_data_in), 32'h0);
    chk("reset_alu_a", 32'(alu_input_a), 32'h0);
    chk("reset_rsp_result", 32'(rsp_result), 32'h0);
    reset     = 1'b0;
    req_valid = 4'b0000;
    #1;
    chk("idle_no_req_ready", 32'(req_ready), 32'h0);

    tick;
    set_req(0, 8'h12, 8'h34, 3'd0);
    req_valid = 4'b0001;
    #1;
    chk("basic_req_ready_T", 32'(req_ready), 32'h1);
    chk("basic_busy_T", 32'(busy), 32'h0);
    tick;
    req_valid = 4'b0000;
    #1;
    chk("basic_data_in_T1", 32'(alu_data_in), 32'h1);
    chk("basic_alu_a", 32'(alu_input_a), 32'h12);
    chk("basic_alu_b", 32'(alu_input_b), 32'h34);
    chk("basic_busy_T1", 32'(busy), 32'h1);
    tick;
    chk("basic_data_in_T2", 32'(alu_data_in), 32'h0);
    chk("basic_rsp_valid_T2", 32'(rsp_valid), 32'h0);
    tick;
    chk("basic_rsp_valid_T3", 32'(rsp_valid), 32'h1);
    chk("basic_rsp_id", 32'(rsp_id), 32'h0);
    chk("basic_rsp_result", 32'(rsp_result), 32'h46);
    tick;
    chk("basic_idle_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("basic_idle_alu_a", 32'(alu_input_a), 32'h0);

    set_req(2, 8'hFF, 8'h01, 3'd1);
    req_valid = 4'b0100;
    #1;
    chk("wrap_req_ready", 32'(req_ready), 32'h4);
    tick;
    req_valid = 4'b0000;
    tick;
    tick;
    chk("wrap_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("wrap_rsp_result", 32'(rsp_result), 32'h00);
    chk("wrap_rsp_id", 32'(rsp_id), 32'h2);
    tick;

    set_req(1, 8'h05, 8'h07, 3'd2);
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    #1;
    chk("stall_req_ready", 32'(req_ready), 32'h2);
    tick;
    chk("stall_op", 32'(alu_operator), 32'h2);
    tick;
    tick;
    for (int i = 0; i < 10; i++) begin
      chk("stall_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("stall_rsp_result", 32'(rsp_result), 32'h0C);
      chk("stall_busy", 32'(busy), 32'h1);
      chk("stall_req_ready", 32'(req_ready), 32'h0);
      tick;
    end
    req_valid = 4'b0000;
    rsp_ready = 1'b1;
    #1;
    chk("stall_rsp_id", 32'(rsp_id), 32'h1);
    tick;
    chk("stall_done_valid", 32'(rsp_valid), 32'h0);
    chk("stall_done_busy", 32'(busy), 32'h0);

    set_req(3, 8'h10, 8'h20, 3'd3);
    req_valid = 4'b1000;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'h8);
    tick;
    req_valid = 4'b0000;
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_alu_data_in", 32'(alu_data_in), 32'h0);
    chk("rst_alu_a", 32'(alu_input_a), 32'h0);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("rst_no_rsp", 32'(rsp_valid), 32'h0);
    end

    for (int i = 0; i < 4; i++) begin
      set_req(i, 8'h10 + 8'(i), 8'h01, 3'(i));
    end
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      onehot = 4'b0001 << exp_ids[k];
      chk("rr_req_ready", 32'(req_ready), 32'(onehot));
      tick;
      chk("rr_data_in", 32'(alu_data_in), 32'h1);
      tick;
      tick;
      chk("rr_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("rr_rsp_id", 32'(rsp_id), 32'(exp_ids[k]));
      chk("rr_rsp_result", 32'(rsp_result), 32'h11 + 32'(exp_ids[k]));
      tick;
    end
    req_valid = 4'b0001;
    #1;
    chk("drop_req_ready", 32'(req_ready), 32'h1);
    tick;
    req_valid = 4'b0010;
    #1;
    chk("drop_busy_req_ready", 32'(req_ready), 32'h0);
    tick;
    req_valid = 4'b0000;
    tick;
    chk("drop_rsp_id", 32'(rsp_id), 32'h0);
    chk("drop_rsp_valid", 32'(rsp_valid), 32'h1);
    tick;
    for (int i = 0; i < 8; i++) begin
      chk("drop_no_rsp", 32'(rsp_valid), 32'h0);
      chk("drop_idle_busy", 32'(busy), 32'h0);
      tick;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
